// File: rtl/mls_pkg.sv
// mls_pkg: shared constants, FSM state type and tap-mask helpers for the
// maximum-length-sequence generator.
package mls_pkg;

   localparam int MIN_ORDER   = 3;
   localparam int ORDER_LIMIT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Primitive feedback taps per order; tap n occupies bit n-1.
   function automatic logic [ORDER_LIMIT-1:0] tap_mask(input logic [4:0] order);
      logic [ORDER_LIMIT-1:0] m;
      case (order)
         5'd3:    m = 16'h0006;
         5'd4:    m = 16'h000C;
         5'd5:    m = 16'h0014;
         5'd6:    m = 16'h0030;
         5'd7:    m = 16'h0060;
         5'd8:    m = 16'h00B8;
         5'd9:    m = 16'h0110;
         5'd10:   m = 16'h0240;
         5'd11:   m = 16'h0500;
         5'd12:   m = 16'h0829;
         5'd13:   m = 16'h100D;
         5'd14:   m = 16'h2015;
         5'd15:   m = 16'h6000;
         5'd16:   m = 16'hD008;
         default: m = 16'h0000;
      endcase
      return m;
   endfunction

   // Ones in every bit position below the order; doubles as the seed value.
   function automatic logic [ORDER_LIMIT-1:0] order_ones(input logic [4:0] order);
      logic [ORDER_LIMIT-1:0] m;
      m = {ORDER_LIMIT{1'b0}};
      for (int i = 0; i < ORDER_LIMIT; i++) begin
         if (5'(i) < order) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/mls_gen_if.sv
// mls_gen_if: control/status bundle between the DAC stream front end (master)
// and the sequence generator (slave). Build option MLS_TAP_OVERRIDE_EN adds the
// custom tap-mask inputs.
interface mls_gen_if
   import mls_pkg::*;
#(
   parameter int DIV_W = 8,
   parameter int REP_W = 3
);
   logic             en;
   logic             start_i;
   logic             stop_i;
   logic [4:0]       order_i;
   logic [DIV_W-1:0] sel_div_i;
   logic [REP_W-1:0] rep_i;
   logic             busy_o;
   logic             flag_o;
   logic             sig_o;
   logic             done_o;
   logic             err_o;
`ifdef MLS_TAP_OVERRIDE_EN
   logic                   tap_sel_i;
   logic [ORDER_LIMIT-1:0] taps_i;
`endif

   modport master (
`ifdef MLS_TAP_OVERRIDE_EN
      output tap_sel_i, taps_i,
`endif
      output en, start_i, stop_i, order_i, sel_div_i, rep_i,
      input  busy_o, flag_o, sig_o, done_o, err_o
   );

   modport slave (
`ifdef MLS_TAP_OVERRIDE_EN
      input  tap_sel_i, taps_i,
`endif
      input  en, start_i, stop_i, order_i, sel_div_i, rep_i,
      output busy_o, flag_o, sig_o, done_o, err_o
   );

endinterface

// File: rtl/mls_lfsr_core.sv
// mls_lfsr_core: variable-order Fibonacci shift register. Bits at or above the
// active order are forced to zero through keep_i; msb_o is bit order-1.
module mls_lfsr_core
   import mls_pkg::*;
#(
   parameter int W = ORDER_LIMIT
) (
   input  logic         clk,
   input  logic         srst,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] keep_i,
   input  logic [W-1:0] mask_i,
   input  logic [4:0]   order_i,
   output logic         msb_o
);

   logic [W-1:0] state_r;
   logic         fb_s;
   logic         msb_s;

   assign fb_s  = ^(state_r & mask_i);
   assign msb_o = msb_s;

   // Seed on load, shift feedback into the LSB on each chip boundary.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_r <= {W{1'b1}};
      end else if (load_i) begin
         state_r <= keep_i;
      end else if (shift_i) begin
         state_r <= {state_r[W-2:0], fb_s} & keep_i;
      end else begin
         state_r <= state_r;
      end
   end

   // Pick bit order-1 without a variable-width index.
   always_comb begin
      msb_s = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (order_i == 5'(i + 1)) begin
            msb_s = state_r[i];
         end else begin
            msb_s = msb_s;
         end
      end
   end

endmodule

// File: rtl/mls_gen.sv
// mls_gen: runtime-configurable MLS generator with chip-rate divider, finite or
// continuous repetition and start/stop/done control. Build option
// MLS_TAP_OVERRIDE_EN lets a start request supply its own tap mask.
module mls_gen
   import mls_pkg::*;
#(
   parameter int MAX_ORDER = 16,
   parameter int DIV_W     = 8,
   parameter int REP_W     = 3
) (
   input logic     clk,
   input logic     srst,
   mls_gen_if.slave bus
);

   state_t               state_r;
   logic                 busy_r, flag_r, done_r, err_r;
   logic [4:0]           order_r;
   logic [DIV_W-1:0]     div_r, div_cnt_r;
   logic [REP_W-1:0]     rep_r, per_cnt_r;
   logic [MAX_ORDER-1:0] chip_cnt_r, mask_r;

   logic                   legal_s, load_s, shift_s;
   logic                   div_term_s, chip_term_s, last_period_s;
   logic                   msb_s;
   logic [REP_W-1:0]       per_next_s;
   logic [MAX_ORDER-1:0]   chip_last_s, keep_s, start_keep_s, run_keep_s;
   logic [MAX_ORDER-1:0]   table_s, new_mask_s;
   logic [ORDER_LIMIT-1:0] start_ones_s, run_ones_s, table_full_s;

   // Decode order legality, counter terminal counts and LFSR control.
   always_comb begin
      legal_s      = (bus.order_i >= 5'(MIN_ORDER)) && (bus.order_i <= 5'(MAX_ORDER));
      start_ones_s = order_ones(bus.order_i);
      run_ones_s   = order_ones(order_r);
      table_full_s = tap_mask(bus.order_i);
      start_keep_s = start_ones_s[MAX_ORDER-1:0];
      run_keep_s   = run_ones_s[MAX_ORDER-1:0];
      table_s      = table_full_s[MAX_ORDER-1:0];
      // Modulo-2^MAX_ORDER arithmetic keeps 2^order-2 exact even at order MAX_ORDER.
      chip_last_s   = ({{(MAX_ORDER-1){1'b0}}, 1'b1} << order_r) - {{(MAX_ORDER-2){1'b0}}, 2'd2};
      div_term_s    = (div_cnt_r == div_r);
      chip_term_s   = (chip_cnt_r == chip_last_s);
      per_next_s    = per_cnt_r + {{(REP_W-1){1'b0}}, 1'b1};
      last_period_s = (rep_r != {REP_W{1'b0}}) && (per_next_s == rep_r);
      load_s        = (state_r == ST_IDLE) && bus.start_i && legal_s;
      shift_s       = (state_r == ST_RUN) && bus.en && !bus.stop_i && div_term_s;
      if (load_s) begin
         keep_s = start_keep_s;
      end else begin
         keep_s = run_keep_s;
      end
`ifdef MLS_TAP_OVERRIDE_EN
      if (bus.tap_sel_i) begin
         new_mask_s = bus.taps_i[MAX_ORDER-1:0] & start_keep_s;
      end else begin
         new_mask_s = table_s & start_keep_s;
      end
`else
      new_mask_s = table_s & start_keep_s;
`endif
   end

   mls_lfsr_core #(.W(MAX_ORDER)) u_core (
      .clk     (clk),
      .srst    (srst),
      .load_i  (load_s),
      .shift_i (shift_s),
      .keep_i  (keep_s),
      .mask_i  (mask_r),
      .order_i (order_r),
      .msb_o   (msb_s)
   );

   assign bus.busy_o = busy_r;
   assign bus.flag_o = flag_r;
   assign bus.done_o = done_r;
   assign bus.err_o  = err_r;
   assign bus.sig_o  = busy_r & msb_s;

   // Control FSM with chip divider, chip/period counters and registered status.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_r    <= ST_IDLE;
         busy_r     <= 1'b0;
         flag_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         order_r    <= 5'd0;
         div_r      <= {DIV_W{1'b0}};
         rep_r      <= {REP_W{1'b0}};
         mask_r     <= {MAX_ORDER{1'b0}};
         div_cnt_r  <= {DIV_W{1'b0}};
         chip_cnt_r <= {MAX_ORDER{1'b0}};
         per_cnt_r  <= {REP_W{1'b0}};
      end else begin
         done_r <= 1'b0;
         err_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start_i) begin
                  if (legal_s) begin
                     order_r    <= bus.order_i;
                     div_r      <= bus.sel_div_i;
                     rep_r      <= bus.rep_i;
                     mask_r     <= new_mask_s;
                     div_cnt_r  <= {DIV_W{1'b0}};
                     chip_cnt_r <= {MAX_ORDER{1'b0}};
                     per_cnt_r  <= {REP_W{1'b0}};
                     busy_r     <= 1'b1;
                     flag_r     <= 1'b1;
                     state_r    <= ST_RUN;
                  end else begin
                     err_r <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (bus.stop_i) begin
                  busy_r  <= 1'b0;
                  flag_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else if (bus.en) begin
                  if (div_term_s) begin
                     div_cnt_r <= {DIV_W{1'b0}};
                     if (chip_term_s) begin
                        chip_cnt_r <= {MAX_ORDER{1'b0}};
                        per_cnt_r  <= per_next_s;
                        if (last_period_s) begin
                           busy_r  <= 1'b0;
                           flag_r  <= 1'b0;
                           done_r  <= 1'b1;
                           state_r <= ST_DONE;
                        end else begin
                           flag_r <= 1'b1;
                        end
                     end else begin
                        chip_cnt_r <= chip_cnt_r + {{(MAX_ORDER-1){1'b0}}, 1'b1};
                        flag_r     <= 1'b0;
                     end
                  end else begin
                     div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                     flag_r    <= 1'b0;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               flag_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mls_gen.sv
// tb_mls_gen: directed bench for mls_gen with a sequence-recurrence reference
// model checked every cycle plus hand-computed literal expectations.
module tb_mls_gen;

   localparam int MAX_ORDER = 16;
   localparam int DIV_W     = 8;
   localparam int REP_W     = 3;

   logic clk = 1'b0;
   logic srst;

   mls_gen_if #(.DIV_W(DIV_W), .REP_W(REP_W)) bus ();

   mls_gen #(.MAX_ORDER(MAX_ORDER), .DIV_W(DIV_W), .REP_W(REP_W)) dut (
      .clk  (clk),
      .srst (srst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Sequence a[t] = XOR over taps k of a[t-k], seeded with n ones.
   bit seq_m [0:65534];
   typedef enum {M_IDLE, M_RUN, M_DONE} mst_t;
   mst_t m_st = M_IDLE;
   int   m_order, m_div, m_rep, m_len;
   int   m_k;          // enabled RUN cycles elapsed since the run began
   bit   m_err = 1'b0;

   function automatic int taps_of(input int n);
      case (n)
         3:  return (1 << 3) | (1 << 2);
         4:  return (1 << 4) | (1 << 3);
         5:  return (1 << 5) | (1 << 3);
         6:  return (1 << 6) | (1 << 5);
         7:  return (1 << 7) | (1 << 6);
         8:  return (1 << 8) | (1 << 6) | (1 << 5) | (1 << 4);
         9:  return (1 << 9) | (1 << 5);
         10: return (1 << 10) | (1 << 7);
         11: return (1 << 11) | (1 << 9);
         12: return (1 << 12) | (1 << 6) | (1 << 4) | (1 << 1);
         13: return (1 << 13) | (1 << 4) | (1 << 3) | (1 << 1);
         14: return (1 << 14) | (1 << 5) | (1 << 3) | (1 << 1);
         15: return (1 << 15) | (1 << 14);
         16: return (1 << 16) | (1 << 15) | (1 << 13) | (1 << 4);
         default: return 0;
      endcase
   endfunction

   task automatic build_seq(input int n);
      int tp;
      int len;
      bit b;
      tp  = taps_of(n);
      len = (1 << n) - 1;
      for (int t = 0; t < len; t++) begin
         if (t < n) begin
            seq_m[t] = 1'b1;
         end else begin
            b = 1'b0;
            for (int k = 1; k <= n; k++) begin
               if (tp[k]) b = b ^ seq_m[t-k];
            end
            seq_m[t] = b;
         end
      end
   endtask

   // Advance the model on every active edge using the inputs the DUT samples.
   always @(posedge clk) begin
      if (srst) begin
         m_st  = M_IDLE;
         m_err = 1'b0;
      end else begin
         m_err = 1'b0;
         case (m_st)
            M_IDLE: begin
               if (bus.start_i) begin
                  if (int'(bus.order_i) >= 3 && int'(bus.order_i) <= MAX_ORDER) begin
                     m_order = int'(bus.order_i);
                     m_div   = int'(bus.sel_div_i);
                     m_rep   = int'(bus.rep_i);
                     m_len   = (1 << m_order) - 1;
                     build_seq(m_order);
                     m_k  = 0;
                     m_st = M_RUN;
                  end else begin
                     m_err = 1'b1;
                  end
               end
            end
            M_RUN: begin
               if (bus.stop_i) begin
                  m_st = M_IDLE;
               end else if (bus.en) begin
                  m_k++;
                  if (m_rep != 0 && m_k == m_rep * m_len * (m_div + 1)) m_st = M_DONE;
               end
            end
            default: m_st = M_IDLE;
         endcase
      end
   end

   // Compare every cycle, mid-cycle, against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("busy", bus.busy_o, (m_st == M_RUN) ? 1 : 0);
         check("done", bus.done_o, (m_st == M_DONE) ? 1 : 0);
         check("err", bus.err_o, m_err ? 1 : 0);
         if (m_st == M_RUN) begin
            check("sig", bus.sig_o, seq_m[(m_k / (m_div + 1)) % m_len]);
            check("flag", bus.flag_o, ((m_k % ((m_div + 1) * m_len)) == 0) ? 1 : 0);
         end else begin
            check("sig_idle", bus.sig_o, 0);
            check("flag_idle", bus.flag_o, 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic go();
      @(posedge clk);
      #2;
   endtask

   // Start is held for cycle T; returns at the drive point of T+1.
   task automatic start_run(input int order, input int div, input int rep);
      go();
      bus.order_i   = 5'(order);
      bus.sel_div_i = DIV_W'(div);
      bus.rep_i     = REP_W'(rep);
      bus.start_i   = 1'b1;
      go();
      bus.start_i   = 1'b0;
   endtask

   logic [6:0] b3 = 7'b1110010;
   logic [3:0] tail4 = 4'b0010;

   initial begin
      int f1, f2, busy_low, done_seen;
      srst          = 1'b1;
      bus.en        = 1'b1;
      bus.start_i   = 1'b0;
      bus.stop_i    = 1'b0;
      bus.order_i   = 5'd0;
      bus.sel_div_i = {DIV_W{1'b0}};
      bus.rep_i     = {REP_W{1'b0}};
`ifdef MLS_TAP_OVERRIDE_EN
      bus.tap_sel_i = 1'b0;
      bus.taps_i    = 16'h0000;
`endif
      go(); go(); go();
      srst   = 1'b0;
      chk_on = 1'b1;
      @(negedge clk);
      check("rst_busy", bus.busy_o, 0);
      check("rst_sig", bus.sig_o, 0);
      check("rst_flag", bus.flag_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_err", bus.err_o, 0);

      // 1: order 3, single period, one cycle per chip
      start_run(3, 0, 1);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i <= 7) check("t1_sig", bus.sig_o, b3[7-i]);
         check("t1_flag", bus.flag_o, (i == 1) ? 1 : 0);
         check("t1_busy", bus.busy_o, (i <= 7) ? 1 : 0);
         check("t1_done", bus.done_o, (i == 8) ? 1 : 0);
      end

      // 2: order 3, three cycles per chip, two periods
      start_run(3, 2, 2);
      for (int i = 1; i <= 44; i++) begin
         @(negedge clk);
         if (i <= 42) check("t2_sig", bus.sig_o, b3[6 - ((i - 1) / 3) % 7]);
         check("t2_flag", bus.flag_o, (i == 1 || i == 22) ? 1 : 0);
         check("t2_done", bus.done_o, (i == 43) ? 1 : 0);
      end

      // 3: order 16, continuous, period wrap at MAX_ORDER
      start_run(16, 0, 0);
      f1 = -1; f2 = -1; busy_low = 0; done_seen = 0;
      for (int i = 1; i <= 65540; i++) begin
         @(negedge clk);
         if (bus.flag_o) begin
            if (f1 < 0) f1 = i;
            else if (f2 < 0) f2 = i;
         end
         if (!bus.busy_o) busy_low++;
         if (bus.done_o) done_seen++;
      end
      check("t3_flag_first", f1, 1);
      check("t3_flag_spacing", f2 - f1, 65535);
      check("t3_busy_low", busy_low, 0);
      check("t3_done_seen", done_seen, 0);
      go();
      bus.stop_i = 1'b1;
      go();
      bus.stop_i = 1'b0;
      @(negedge clk);
      check("t3_stopped", bus.busy_o, 0);

      // 4: order 3, enable low for five cycles after the third chip
      start_run(3, 0, 1);
      @(negedge clk); @(negedge clk); @(negedge clk);
      go();
      bus.en = 1'b0;
      for (int j = 4; j <= 8; j++) begin
         @(negedge clk);
         check("t4_hold_sig", bus.sig_o, 0);
         check("t4_hold_busy", bus.busy_o, 1);
         if (j < 8) go();
      end
      go();
      bus.en = 1'b1;
      for (int i = 9; i <= 14; i++) begin
         @(negedge clk);
         if (i <= 12) check("t4_sig", bus.sig_o, tail4[12-i]);
         check("t4_done", bus.done_o, (i == 13) ? 1 : 0);
      end

      // 5: illegal orders, then a stopped continuous run
      start_run(2, 0, 0);
      @(negedge clk);
      check("t5_err2", bus.err_o, 1);
      check("t5_busy2", bus.busy_o, 0);
      start_run(17, 0, 0);
      @(negedge clk);
      check("t5_err17", bus.err_o, 1);
      check("t5_busy17", bus.busy_o, 0);
      start_run(5, 0, 0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 6) check("t5_chip5", bus.sig_o, 0);
         if (i == 9) check("t5_chip8", bus.sig_o, 1);
      end
      go();
      bus.stop_i = 1'b1;
      @(negedge clk);
      check("t5_chip10", bus.sig_o, 0);
      go();
      bus.stop_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t5_stop_busy", bus.busy_o, 0);
         check("t5_stop_done", bus.done_o, 0);
      end

      // 6: synchronous reset mid-run, then restart from the seed
      start_run(8, 0, 0);
      for (int i = 0; i < 20; i++) @(negedge clk);
      go();
      srst = 1'b1;
      @(negedge clk);
      go();
      srst = 1'b0;
      @(negedge clk);
      check("t6_rst_busy", bus.busy_o, 0);
      check("t6_rst_sig", bus.sig_o, 0);
      check("t6_rst_flag", bus.flag_o, 0);
      start_run(8, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         check("t6_sig", bus.sig_o, (i <= 8) ? 1 : 0);
         check("t6_flag", bus.flag_o, (i == 1) ? 1 : 0);
      end
      go();
      bus.stop_i = 1'b1;
      go();
      bus.stop_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
